// File: rtl/sum_serial_ctrl.sv
// Bit-serial adder controller: streams operand bits LSB first into an external
// 1-bit full adder and assembles the WIDTH-bit sum and final carry.
//
// state | meaning
// IDLE  | waiting for start; fa_* held at 0
// RUN   | one bit pair per cycle into the full adder, WIDTH cycles
// DONE  | single-cycle done pulse, result registers valid
module sum_serial_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_ci,
   input  logic             fa_s,
   input  logic             fa_co
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] s_next;

   // Newest adder bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   assign s_next = {fa_s, s_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh    <= op_a;
                  b_sh    <= op_b;
                  carry_q <= cin;
                  s_sh    <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               s_sh    <= s_next;
               carry_q <= fa_co;
               if (cnt == CNT_LAST) begin
                  sum   <= s_next;
                  cout  <= fa_co;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign fa_a  = (state == RUN) & a_sh[0];
   assign fa_b  = (state == RUN) & b_sh[0];
   assign fa_ci = (state == RUN) & carry_q;

endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Bench for sum_serial_ctrl: full adder on the fa_* nets, cycle-level reference
// model of the add sequence, per-cycle compare plus directed literal checks.
module tb_sum_serial_ctrl;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, fa_a, fa_b, fa_ci, fa_s, fa_co;
   logic [W-1:0] sum;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // sum1b
   assign fa_s  = fa_a ^ fa_b ^ fa_ci;
   assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

   sum_serial_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout),
      .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase = cycles since the accept edge (-1 when idle).
   int m_phase = -1;
   int m_a = 0, m_b = 0, m_cin = 0;
   int m_sum = 0, m_cout = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= -1;
         m_sum   <= 0;
         m_cout  <= 0;
      end else if (m_phase < 0) begin
         if (start) begin
            m_a     <= int'(op_a);
            m_b     <= int'(op_b);
            m_cin   <= int'(cin);
            m_phase <= 0;
         end
      end else if (m_phase < W) begin
         m_phase <= m_phase + 1;
         if (m_phase == W - 1) begin
            m_sum  <= (m_a + m_b + m_cin) % (1 << W);
            m_cout <= (m_a + m_b + m_cin) >> W;
         end
      end else begin
         m_phase <= -1;
      end
   end

   always @(negedge clk) begin
      int k, mask, ea, eb, ec;
      k = m_phase;
      if (k >= 0 && k < W) begin
         mask = (1 << k) - 1;
         ea = (m_a >> k) & 1;
         eb = (m_b >> k) & 1;
         ec = (((m_a & mask) + (m_b & mask) + m_cin) >> k) & 1;
      end else begin
         ea = 0; eb = 0; ec = 0;
      end
      check("busy", int'(busy), int'(m_phase >= 0));
      check("done", int'(done), int'(m_phase == W));
      check("sum", int'(sum), m_sum);
      check("cout", int'(cout), m_cout);
      check("fa_a", int'(fa_a), ea);
      check("fa_b", int'(fa_b), eb);
      check("fa_ci", int'(fa_ci), ec);
   end

   int lat;

   task automatic do_add(input int a, input int b, input int c);
      int n;
      n = 0;
      while (busy && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      op_a = W'(a); op_b = W'(b); cin = c[0];
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   initial begin
      int busy_cnt, last_done, n_done;
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_sum", int'(sum), 0);
      check("rst_fa", int'({fa_a, fa_b, fa_ci}), 0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      // 1: latency and busy length
      op_a = 4'd3; op_b = 4'd5; cin = 1'b0; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      busy_cnt = 0; lat = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (lat == 0 && done) lat = i + 1;
      end
      check("t1_latency", lat, 5);
      check("t1_busy_cycles", busy_cnt, 5);
      check("t1_sum", int'(sum), 8);
      check("t1_cout", int'(cout), 0);

      // 2: carries out of the top bit
      do_add(15, 1, 0);
      check("t2a_sum", int'(sum), 0);
      check("t2a_cout", int'(cout), 1);
      do_add(15, 15, 1);
      check("t2b_sum", int'(sum), 15);
      check("t2b_cout", int'(cout), 1);

      // 3: start held high -> back-to-back adds every W+2 cycles
      @(posedge clk); #2;
      op_a = 4'd1; op_b = 4'd2; cin = 1'b0; start = 1'b1;
      last_done = -1; n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            if (last_done >= 0) check("t3_period", i - last_done, W + 2);
            last_done = i;
            n_done++;
         end
      end
      check("t3_count", n_done, 6);
      check("t3_sum", int'(sum), 3);
      @(posedge clk); #2;
      start = 1'b0;
      for (int i = 0; i < 8; i++) @(posedge clk);
      #2;

      // 4: reset mid-RUN
      op_a = 4'd9; op_b = 4'd6; cin = 1'b0; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("t4_busy", int'(busy), 0);
      check("t4_done", int'(done), 0);
      check("t4_sum", int'(sum), 0);
      check("t4_cout", int'(cout), 0);
      check("t4_fa", int'({fa_a, fa_b, fa_ci}), 0);
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("t4_no_done", n_done, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #2;
      do_add(9, 6, 0);
      check("t4_sum_after", int'(sum), 15);
      check("t4_cout_after", int'(cout), 0);

      // 5: exhaustive
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               do_add(a, b, c);
               check("t5_result", int'({cout, sum}), a + b + c);
            end

      // random start/operand traffic, model compare only
      @(posedge clk); #2;
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 3) == 0);
         op_a  = W'($urandom);
         op_b  = W'($urandom);
         cin   = 1'($urandom);
         @(posedge clk); #2;
      end
      start = 1'b0;
      for (int i = 0; i < 10; i++) @(posedge clk);
      @(negedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
